// File: rtl/srl16_fifo_pkg.sv
// rtl/srl16_fifo_pkg.sv - shared constants and parameter check for the SRL16-style FIFO
package srl16_fifo_pkg;

  localparam int SRL_ADDR_W    = 4;
  localparam int SRL_MAX_DEPTH = 16;
  localparam int CNT_W         = 5;

  // Legal depths are powers of two that fit the 4-bit SRL address.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && (depth <= SRL_MAX_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/srl16_fifo_shift_bank.sv
// rtl/srl16_fifo_shift_bank.sv - WIDTH lanes of DEPTH-deep addressable shift registers
module srl_shift_bank
  import srl16_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                  CLK,
  input  logic                  CE,
  input  logic [WIDTH-1:0]      D,
  input  logic [SRL_ADDR_W-1:0] A,
  output logic [WIDTH-1:0]      Q
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] data [DEPTH];

  // Shift every lane by one position on an enabled edge; no reset on storage.
  always_ff @(posedge CLK) begin
    if (CE) begin
      data[0] <= D;
      for (int i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
      end
    end
  end

  // Upper address bits are ignored when the bank is shallower than 16.
  assign Q = data[A[IDX_W-1:0]];

endmodule

// File: rtl/srl16_fifo.sv
// rtl/srl16_fifo.sv - SRL16-style synchronous FIFO controller, optional output register via SRL16_FIFO_OREG_EN
module srl16_fifo
  import srl16_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] DIN,
  output logic             FULL,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] DOUT,
  output logic             EMPTY,
  output logic [CNT_W-1:0] COUNT,
  output logic             ERR_OVF,
  output logic             ERR_UDF
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam bit PARAM_OK = depth_ok(DEPTH) && (WIDTH >= 1) && (WIDTH <= 64);
`ifdef SRL16_FIFO_OREG_EN
  localparam int MAX_COUNT = DEPTH + 1;
`else
  localparam int MAX_COUNT = DEPTH;
`endif

  logic [CNT_W-1:0]      srl_count;
  logic                  srl_full;
  logic                  srl_empty;
  logic [SRL_ADDR_W-1:0] srl_addr;
  logic [WIDTH-1:0]      srl_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  pop;

  assign srl_full  = (srl_count == DEPTH_C);
  assign srl_empty = (srl_count == '0);
  // Oldest entry sits at count-1 because new data always enters at address 0.
  assign srl_addr  = SRL_ADDR_W'(srl_count - CNT_W'(1));

  srl_shift_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_bank (
    .CLK (CLK),
    .CE  (wr_acc),
    .D   (DIN),
    .A   (srl_addr),
    .Q   (srl_q)
  );

`ifdef SRL16_FIFO_OREG_EN
  logic             oreg_vld;
  logic [WIDTH-1:0] oreg;

  assign rd_acc = RD_EN & oreg_vld;
  // Refill the holding register whenever it is empty or being consumed.
  assign pop    = (~oreg_vld | rd_acc) & ~srl_empty;
  assign wr_acc = WR_EN & (~srl_full | pop) & ~RST;

  // Holding register in front of DOUT; cleared on reset and when drained.
  always_ff @(posedge CLK) begin
    if (RST) begin
      oreg_vld <= 1'b0;
      oreg     <= '0;
    end else if (pop) begin
      oreg_vld <= 1'b1;
      oreg     <= srl_q;
    end else if (rd_acc) begin
      oreg_vld <= 1'b0;
      oreg     <= '0;
    end
  end

  assign DOUT  = oreg;
  assign EMPTY = ~oreg_vld;
  assign COUNT = srl_count + CNT_W'(oreg_vld);
`else
  assign rd_acc = RD_EN & ~srl_empty;
  assign pop    = rd_acc;
  // A read in the same cycle frees the slot, so a full FIFO still takes the write.
  assign wr_acc = WR_EN & (~srl_full | RD_EN) & ~RST;

  assign DOUT  = srl_empty ? '0 : srl_q;
  assign EMPTY = srl_empty;
  assign COUNT = srl_count;
`endif

  assign FULL = srl_full;

  // SRL occupancy: push and pop together leave it unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      srl_count <= '0;
    end else begin
      case ({wr_acc, pop})
        2'b10:   srl_count <= srl_count + CNT_W'(1);
        2'b01:   srl_count <= srl_count - CNT_W'(1);
        default: srl_count <= srl_count;
      endcase
    end
  end

  // Registered one-cycle pulses for rejected requests; silent during reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_OVF <= 1'b0;
      ERR_UDF <= 1'b0;
    end else begin
      ERR_OVF <= WR_EN & ~wr_acc;
      ERR_UDF <= RD_EN & ~rd_acc;
    end
  end

  a_param_ok : assert property (@(posedge CLK) PARAM_OK);
  a_count_max : assert property (@(posedge CLK) disable iff (RST) (int'(COUNT) <= MAX_COUNT));

endmodule

// File: doc/srl16_fifo.md
Name: srl16_fifo

Overview:
- Synchronous FIFO built on an SRL16-style shift-register bank: WIDTH parallel 16-bit shift registers plus the controller that drives their shared clock-enable and 4-bit read address.
- Occupies the stage directly around the SRL primitive: generates CE/A[3:0] into the storage and consumes its Q outputs.
- Used as a small elastic buffer between producer and consumer logic in the same clock domain.
- First-word-fall-through by default.

Parameters:
- WIDTH, 8, data bits per entry (1..64).
- DEPTH, 16, storage entries; power of two, 2..16. Address width is fixed at 4; upper address bits are unused when DEPTH < 16.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- WR_EN  input  1  write request.
- DIN  input  WIDTH  write data.
- FULL  output  1  occupancy == DEPTH.
- RD_EN  input  1  read/pop request.
- DOUT  output  WIDTH  head-of-FIFO data.
- EMPTY  output  1  no data available at DOUT.
- COUNT  output  5  entries held, 0..16 (0..17 with the optional register).
- ERR_OVF  output  1  one-cycle pulse: write rejected.
- ERR_UDF  output  1  one-cycle pulse: read rejected.

Behaviour:
- Storage:
  - An accepted write shifts all lanes: data[i] <= data[i-1]; data[0] <= DIN.
  - Storage contents are never cleared, including by RST.
- Read address = count-1; DOUT = data[count-1] combinationally.
- Handshake rules:
  - wr_acc = WR_EN & (~FULL | RD_EN). A write while full is accepted if a read occurs in the same cycle; the oldest entry at address 15 is read before the shift.
  - rd_acc = RD_EN & ~EMPTY.
- Count update:
  - wr_acc only: count+1.
  - rd_acc only: count-1.
  - Both: unchanged. Read address holds, so the new head is the next-oldest entry.
  - Neither: unchanged.
- Flags: EMPTY = (count==0); FULL = (count==DEPTH). Both are decoded from registered count, so they are glitch-free and change only on CLK.
- Empty output:
  - DOUT is forced to 0 when EMPTY.
  - Write into empty: DOUT is valid and EMPTY=0 in the next cycle (latency 1).
- Error pulses:
  - ERR_OVF <= WR_EN & FULL & ~RD_EN.
  - ERR_UDF <= RD_EN & EMPTY.
  - Both are registered and assert for 1 cycle per offending cycle.
  - Rejected operations leave count and storage untouched.
- Reset:
  - RST=1 at any edge, including mid-stream or concurrent with WR_EN/RD_EN: count=0, EMPTY=1, FULL=0, ERR_*=0, DOUT=0. RST wins over all requests.
  - Requests in the reset cycle are ignored and raise no error pulses.
- Arithmetic: count is 5 bits and never wraps. Saturation cannot occur given the acceptance rules; an assertion checks count <= DEPTH(+1).

Optional Feature:
- Macro: SRL16_FIFO_OREG_EN.
- Defined:
  - A registered output stage sits after the SRL. DOUT/EMPTY come from a holding register (oreg, oreg_vld).
  - The SRL is popped into oreg when (~oreg_vld | rd_acc) and srl_count != 0.
  - Write-to-DOUT latency is 2 cycles.
  - Capacity is DEPTH+1, and COUNT = srl_count + oreg_vld.
  - FULL refers to SRL occupancy == DEPTH.
  - Reset clears oreg_vld and forces oreg=0.
- Undefined: the combinational path described above, with capacity DEPTH.

Decomposition:
- Package srl16_fifo_pkg holds:
  - constants SRL_ADDR_W=4 and SRL_MAX_DEPTH=16;
  - count width localparam CNT_W=5;
  - function depth_ok() for parameter checking.
- Sub-module srl_shift_bank holds the WIDTH×DEPTH rising-edge shift storage:
  - inputs CLK, CE, D[WIDTH], A[3:0];
  - output Q[WIDTH];
  - no reset.
- Controller, flags, error pulses and the optional output register live in srl16_fifo.

Test Plan:
- Reset then write 0x11,0x22,0x33 on consecutive cycles, RD_EN=0 -> COUNT=3, EMPTY=0, DOUT=0x11 one cycle after the first write.
- Fill 16 entries 0x00..0x0F -> FULL=1 at COUNT=16. Extra write with RD_EN=0 -> ERR_OVF pulses for 1 cycle and COUNT stays 16. Drain 16 reads -> data 0x00..0x0F in order, then EMPTY=1.
- At FULL, WR_EN=RD_EN=1 with DIN=0xAA -> 0x00 popped, COUNT stays 16, 0xAA emerges as the 16th subsequent read.
- Empty FIFO, RD_EN=1 -> ERR_UDF pulses once, DOUT=0, COUNT=0. Simultaneous WR_EN+RD_EN on empty -> write accepted, read rejected, COUNT=1.
- Load 5 entries, assert RST with WR_EN=1 -> next cycle COUNT=0, EMPTY=1, no error pulse. A following write of 0x5A is read back as 0x5A.
- With SRL16_FIFO_OREG_EN: write 0x77 into empty -> DOUT=0x77 and EMPTY=0 exactly 2 cycles later. Fill to COUNT=17 -> FULL=1, and all 17 values drain in order.
